serial_bit_tx: RTL and testbench

Parallel-to-serial bit transmitter that produces one data bit per clock on `sout`, framed by `sout_valid`/`sout_last`. It is the sending end for the single-bit sampling chain built from master-slave D flip-flops: its `sout` drives the `d` input of a downstream capture flop. A valid/ready handshake on the parallel side accepts words. Back-to-back words stream with no idle cycle between frames.

---
 rtl/serial_tx_pkg.sv | 15 +
 rtl/serial_bit_tx.sv | 84 ++++++++
 tb/tb_serial_bit_tx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types for the serial bit transmitter: FSM state encoding and the
// counter-width helper used to size the bit counter.
package serial_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    // A one-bit word still needs a one-bit counter, so $clog2 alone is not enough
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter: accepts a word on a valid/ready handshake and
// emits one bit per clock on sout, framed by sout_valid/sout_last, gapless.
module serial_bit_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);

    tx_state_t        state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic             accept;

    // Ready in IDLE, or on the final bit of a frame so the next word follows with no gap
    assign in_ready = rst_n && ((state == IDLE) || ((state == SHIFT) && (cnt == '0)));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = SHIFT;
                    shreg_nx = in_data;
                    cnt_nx   = CNT_LOAD;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    if (accept) begin
                        shreg_nx = in_data;
                        cnt_nx   = CNT_LOAD;
                    end else begin
                        state_nx = IDLE;
                        shreg_nx = '0;
                    end
                end else begin
                    shreg_nx = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                    cnt_nx   = cnt - CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                shreg_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            shreg <= shreg_nx;
        end
    end

    // The shift register is cleared whenever the FSM idles, so sout is already 0 there
    assign sout       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign sout_valid = (state == SHIFT);
    assign sout_last  = (state == SHIFT) && (cnt == '0);
    assign busy       = sout_valid;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Self-checking bench for serial_bit_tx: three instances (8-bit MSB-first,
// 8-bit LSB-first, 1-bit) checked against a queue-based bit-stream model.
module tb_serial_bit_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] data8;
    logic [0:0] data1;

    logic rdy [3];
    logic so  [3];
    logic sv  [3];
    logic sl  [3];
    logic bz  [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_bit_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_data(data8), .in_valid(in_valid),
        .in_ready(rdy[0]), .sout(so[0]), .sout_valid(sv[0]), .sout_last(sl[0]), .busy(bz[0])
    );

    serial_bit_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_data(data8), .in_valid(in_valid),
        .in_ready(rdy[1]), .sout(so[1]), .sout_valid(sv[1]), .sout_last(sl[1]), .busy(bz[1])
    );

    serial_bit_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_data(data1), .in_valid(in_valid),
        .in_ready(rdy[2]), .sout(so[2]), .sout_valid(sv[2]), .sout_last(sl[2]), .busy(bz[2])
    );

    // Reference: each instance owns a queue of {bit, last} still to appear on sout;
    // the head is the bit shown in the current cycle.
    logic [1:0] mq [3][$];
    int         mw   [3] = '{8, 8, 1};
    bit         mmsb [3] = '{1'b1, 1'b0, 1'b1};

    function automatic logic m_ready(int i);
        return rst_n && (mq[i].size() <= 1);
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic check_output();
        for (int i = 0; i < 3; i++) begin
            logic [4:0] exp;
            logic [4:0] act;
            if (mq[i].size() > 0)
                exp = {m_ready(i), mq[i][0][1], 1'b1, mq[i][0][0], 1'b1};
            else
                exp = {m_ready(i), 4'b0000};
            act = {rdy[i], so[i], sv[i], sl[i], bz[i]};
            check($sformatf("model_inst%0d", i), 32'(act), 32'(exp));
        end
    endtask

    task automatic model_edge();
        logic acc [3];
        for (int i = 0; i < 3; i++) acc[i] = in_valid && m_ready(i);
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                mq[i].delete();
            end else begin
                logic [31:0] word;
                if (mq[i].size() > 0) void'(mq[i].pop_front());
                word = (i == 2) ? {31'b0, data1} : {24'b0, data8};
                if (acc[i]) begin
                    for (int b = 0; b < mw[i]; b++) begin
                        int idx;
                        idx = mmsb[i] ? (mw[i] - 1 - b) : b;
                        mq[i].push_back({word[idx], (b == mw[i] - 1) ? 1'b1 : 1'b0});
                    end
                end
            end
        end
    endtask

    // Called at a falling edge: drive inputs, let in_ready settle, compare with model
    task automatic apply_stimulus(logic r, logic v, logic [7:0] d8, logic d1);
        rst_n    = r;
        in_valid = v;
        data8    = d8;
        data1    = d1;
        #1;
        check_output();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drain(int n);
        for (int k = 0; k < n; k++) begin
            apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
            tick();
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic s, logic va, logic l);
        vec_t t;
        t.v   = v;
        t.d   = d;
        t.exp = {r, s, va, l};
        return t;
    endfunction

    initial begin
        logic [7:0] a5;
        logic [7:0] x3c;
        logic [7:0] x80;
        a5  = 8'hA5;
        x3c = 8'h3C;
        x80 = 8'h80;

        // Table rows hold {in_valid, in_data, expected {in_ready, sout, sout_valid, sout_last}} of u_msb
        tbl[0] = mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 8; c++)
            tbl[c] = mk(1'b0, 8'h00, c == 8, a5[8-c], 1'b1, c == 8);
        tbl[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 11; c <= 18; c++)
            tbl[c] = mk(1'b1, 8'h3C, c == 18, a5[18-c], 1'b1, c == 18);
        for (int c = 19; c <= 26; c++)
            tbl[c] = mk(1'b0, 8'h00, c == 26, x3c[26-c], 1'b1, c == 26);
        tbl[27] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        rst_n    = 1'b0;
        in_valid = 1'b0;
        data8    = 8'h00;
        data1    = 1'b0;
        @(negedge clk);
        tick();
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check("reset_outputs", {28'b0, so[0], sv[0], sl[0], rdy[0]}, 32'h0);
        tick();

        $display("[TB] table: single word and back-to-back frames");
        for (int j = 0; j < 28; j++) begin
            apply_stimulus(1'b1, tbl[j].v, tbl[j].d, 1'b0);
            check($sformatf("table_row%0d", j), {28'b0, rdy[0], so[0], sv[0], sl[0]}, {28'b0, tbl[j].exp});
            tick();
        end
        drain(3);

        $display("[TB] LSB-first 8'h01");
        apply_stimulus(1'b1, 1'b1, 8'h01, 1'b0);
        tick();
        for (int b = 0; b < 8; b++) begin
            apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
            check("lsb_frame", {29'b0, so[1], sv[1], sl[1]}, {29'b0, b == 0, 1'b1, b == 7});
            tick();
        end
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        check("lsb_idle", {31'b0, sv[1]}, 32'h0);
        tick();
        drain(2);

        $display("[TB] input changes ignored while busy");
        apply_stimulus(1'b1, 1'b1, 8'hFF, 1'b0);
        tick();
        for (int c = 1; c <= 8; c++) begin
            apply_stimulus(1'b1, 1'b1, 8'h00, 1'b0);
            check("busy_ignore", {30'b0, rdy[0], so[0]}, {30'b0, c == 8, 1'b1});
            tick();
        end
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        check("busy_next_frame", {30'b0, so[0], sv[0]}, 32'h1);
        tick();
        drain(10);

        $display("[TB] reset mid-frame");
        apply_stimulus(1'b1, 1'b1, 8'hA5, 1'b1);
        tick();
        for (int c = 1; c <= 3; c++) begin
            apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
            check("rst_pre_bits", {31'b0, so[0]}, {31'b0, a5[8-c]});
            tick();
        end
        apply_stimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        check("rst_ready_low", {29'b0, rdy[0], rdy[1], rdy[2]}, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        check("rst_outputs_cleared", {28'b0, so[0], sv[0], sl[0], bz[0]}, 32'h0);
        tick();
        apply_stimulus(1'b1, 1'b1, 8'h80, 1'b0);
        check("rst_release", {29'b0, rdy[0], sv[0], sv[2]}, 32'h4);
        tick();
        for (int c = 0; c < 8; c++) begin
            apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
            check("rst_new_word", {30'b0, so[0], sv[0]}, {30'b0, x80[7-c], 1'b1});
            tick();
        end
        drain(3);

        $display("[TB] WIDTH=1 continuous stream");
        apply_stimulus(1'b1, 1'b1, 8'h00, 1'b1);
        tick();
        apply_stimulus(1'b1, 1'b1, 8'h00, 1'b0);
        check("w1_bit1", {29'b0, so[2], sv[2], sl[2]}, 32'h7);
        tick();
        apply_stimulus(1'b1, 1'b1, 8'h00, 1'b1);
        check("w1_bit2", {29'b0, so[2], sv[2], sl[2]}, 32'h3);
        tick();
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        check("w1_bit3", {29'b0, so[2], sv[2], sl[2]}, 32'h7);
        tick();
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        check("w1_idle", {31'b0, sv[2]}, 32'h0);
        tick();
        drain(10);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 800; n++) begin
            apply_stimulus($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
                           8'($urandom), 1'($urandom));
            tick();
        end
        drain(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
